// File: rtl/serial_tx.sv
// serial_tx: 8N1 UART transmitter, 8E1 when SERIAL_TX_PARITY_EN is defined; CLOCKS_PER_BAUD clocks per bit.
// Latency: start bit appears 1 cycle after i_wr is accepted; o_busy spans F*CLOCKS_PER_BAUD cycles (F=10, or 11 with parity).
// Backpressure: i_wr is dropped while o_busy is high (no queuing); a write is taken on the first cycle o_busy is low.
module serial_tx #(
    parameter logic [23:0] CLOCKS_PER_BAUD = 24'd868
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_wr,
    input  logic [7:0] i_data,
    output logic       o_uart_tx,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SERIAL_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    // Initialisers give the same power-up state as a reset.
    state_t      r_state    = IDLE;
    logic [23:0] r_baud_cnt = 24'd0;
    logic [2:0]  r_bit_idx  = 3'd0;
    logic [7:0]  r_shift    = 8'd0;
    logic        r_tx       = 1'b1;
    logic        r_busy     = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    logic        r_parity   = 1'b0;
`endif

    logic w_baud_end;
    assign w_baud_end = (r_baud_cnt == 24'd0);

    assign o_uart_tx = r_tx;
    assign o_busy    = r_busy;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_baud_cnt <= 24'd0;
            r_bit_idx  <= 3'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_wr) begin
                        r_state    <= START;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_baud_cnt <= CLOCKS_PER_BAUD - 24'd1;
                        r_bit_idx  <= 3'd0;
                        r_shift    <= i_data;
`ifdef SERIAL_TX_PARITY_EN
                        r_parity   <= ^i_data;
`endif
                    end
                end
                START: begin
                    if (w_baud_end) begin
                        r_state    <= DATA;
                        r_tx       <= r_shift[0];
                        r_baud_cnt <= CLOCKS_PER_BAUD - 24'd1;
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 24'd1;
                    end
                end
                DATA: begin
                    if (w_baud_end) begin
                        r_baud_cnt <= CLOCKS_PER_BAUD - 24'd1;
                        if (r_bit_idx == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                            r_state <= PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            // Bit 0 is already on the line, so the next bit is shift[1].
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 24'd1;
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                PARITY: begin
                    if (w_baud_end) begin
                        r_state    <= STOP;
                        r_tx       <= 1'b1;
                        r_baud_cnt <= CLOCKS_PER_BAUD - 24'd1;
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 24'd1;
                    end
                end
`endif
                STOP: begin
                    if (w_baud_end) begin
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_bit_idx <= 3'd0;
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 24'd1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_tx       <= 1'b1;
                    r_busy     <= 1'b0;
                    r_baud_cnt <= 24'd0;
                    r_bit_idx  <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed plus random frames for serial_tx at CLOCKS_PER_BAUD=4, checked cycle by cycle against a frame-level line model.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_serial_tx;

    localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int F = 11;
`else
    localparam int F = 10;
`endif
    localparam int NO_EVT = -100;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       wr    = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       tx;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    serial_tx #(.CLOCKS_PER_BAUD(24'd4)) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_wr     (wr),
        .i_data   (data),
        .o_uart_tx(tx),
        .o_busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected line level k cycles into a frame: start, 8 data LSB first, [even parity], stop.
    function automatic logic exp_line(input logic [7:0] d, input int k);
        int b;
        b = k / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef SERIAL_TX_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_tx@%0d", tag, i), tx, 1'b1);
            chk($sformatf("%s_busy@%0d", tag, i), busy, 1'b0);
            step();
        end
    endtask

    // Sends d, optionally raising i_wr with inj_d during cycles [inj_at, inj_at+inj_len)
    // of the frame, and optionally resetting at cycle abort_at.
    task automatic frame(input logic [7:0] d, input int inj_at, input int inj_len,
                         input logic [7:0] inj_d, input int abort_at);
        logic inj;
        wr   = 1'b1;
        data = d;
        step();
        for (int k = 0; k < F * CPB; k++) begin
            inj  = (k >= inj_at) && (k < inj_at + inj_len);
            wr   = inj;
            data = inj ? inj_d : 8'($urandom);
            chk($sformatf("tx_%02h@%0d", d, k), tx, exp_line(d, k));
            chk($sformatf("busy_%02h@%0d", d, k), busy, 1'b1);
            if (k == abort_at) begin
                rst = 1'b1;
                wr  = 1'b0;
                step();
                rst = 1'b0;
                chk("abort_tx", tx, 1'b1);
                chk("abort_busy", busy, 1'b0);
                return;
            end
            step();
        end
        inj = (F * CPB >= inj_at) && (F * CPB < inj_at + inj_len);
        wr  = inj;
        if (inj) data = inj_d;
        chk($sformatf("end_busy_%02h", d), busy, 1'b0);
        chk($sformatf("end_tx_%02h", d), tx, 1'b1);
    endtask

    initial begin
        #1;
        chk("pwrup_tx", tx, 1'b1);
        chk("pwrup_busy", busy, 1'b0);

        rst = 1'b1;
        step();
        step();
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        idle(3, "idle0");

        frame(8'h41, NO_EVT, 0, 8'h00, NO_EVT);
        idle(2, "after41");

        for (int i = 0; i < 6; i++) begin
            frame(8'($urandom), NO_EVT, 0, 8'h00, NO_EVT);
            idle(int'($urandom_range(0, 3)), "rnd_gap");
        end

        // i_wr held high across the frame: second byte starts right after busy drops.
        frame(8'h55, 0, F * CPB + 1, 8'hAA, NO_EVT);
        frame(8'hAA, NO_EVT, 0, 8'h00, NO_EVT);
        idle(2, "after_b2b");

        frame(8'h00, 10, 1, 8'hFF, NO_EVT);
        idle(1, "after00");

        frame(8'h3C, NO_EVT, 0, 8'h00, 15);
        idle(2, "post_abort");
        frame(8'h3C, NO_EVT, 0, 8'h00, NO_EVT);
        idle(1, "after3c");

        rst  = 1'b1;
        wr   = 1'b1;
        data = 8'($urandom);
        step();
        rst = 1'b0;
        wr  = 1'b0;
        idle(8, "rst_wr");

`ifdef SERIAL_TX_PARITY_EN
        frame(8'h41, NO_EVT, 0, 8'h00, NO_EVT);
        idle(1, "par41");
        frame(8'h07, NO_EVT, 0, 8'h00, NO_EVT);
        idle(1, "par07");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
